// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / divide unit feeding HI/LO for mfhi/mflo.
// Optional MULTDIV_UNSIGNED_EN adds is_unsigned for multu/divu.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
`ifdef MULTDIV_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic               neg_lo, neg_hi, is_div;

   logic               uns, sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic               div_ge;

`ifdef MULTDIV_UNSIGNED_EN
   assign uns = is_unsigned;
`else
   assign uns = 1'b0;
`endif

   assign sign_a = a_in[WIDTH-1] & ~uns;
   assign sign_b = b_in[WIDTH-1] & ~uns;
   assign mag_a  = sign_a ? -a_in : a_in;
   assign mag_b  = sign_b ? -b_in : b_in;

   // Multiply: acc = {partial, multiplier}; add into the top half, shift right.
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

   // Divide: acc = {remainder, dividend/quotient}; remainder < divisor keeps the
   // trial difference inside WIDTH+1 signed bits, so its MSB is the borrow.
   assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opnd};
   assign div_ge   = ~div_diff[WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         is_div   <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start_mult) begin
                  opnd   <= mag_a;
                  acc    <= {{WIDTH{1'b0}}, mag_b};
                  neg_lo <= sign_a ^ sign_b;
                  neg_hi <= sign_a ^ sign_b;
                  is_div <= 1'b0;
                  cnt    <= CW'(WIDTH-1);
                  busy   <= 1'b1;
                  state  <= MUL;
               end else if (start_div) begin
                  if (b_in == '0) begin
                     div_zero <= 1'b1;
                  end else begin
                     opnd   <= mag_b;
                     acc    <= {{WIDTH{1'b0}}, mag_a};
                     neg_lo <= sign_a ^ sign_b;
                     neg_hi <= sign_a;
                     is_div <= 1'b1;
                     cnt    <= CW'(WIDTH-1);
                     busy   <= 1'b1;
                     state  <= DIV;
                  end
               end
            end
            MUL: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= FIX;
            end
            DIV: begin
               acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                       acc[WIDTH-2:0], div_ge};
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  lo_out <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                  hi_out <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
               end else begin
                  {hi_out, lo_out} <= neg_lo ? -acc : acc;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
